// File: rtl/dino_frame_scheduler.sv
// dino_frame_scheduler
// Per-frame game sequencer for the dino runner VGA overlay. Motion (jump
// physics, obstacle scroll/respawn, scoring) advances once per rising edge of
// screen_ready; the IDLE/RUN/OVER game state is driven by jump_btn edges and
// by collision_detected, which is sampled on frame ticks while running.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   screen_ready          : VGA end-of-frame level (rising edge = frame tick)
//   jump_btn              : debounced jump/start button (rising edge used)
//   collision_detected    : overlap flag from the VGA block
//   x_coor, y_coor        : dino left x / bottom y (zero-extended)
//   x_coor_obstacle       : obstacle left x (zero-extended)
//   y_coor_obstacle       : obstacle bottom y (constant ground line)
//   random_generator_clk  : [0] toggles on respawn, [1] toggles on jump start
//   score                 : obstacles cleared, saturating
//   game_over             : high in OVER
//   state                 : IDLE=0, RUN=1, OVER=2
module dino_frame_scheduler #(
  parameter int DINO_X       = 100,
  parameter int GROUND_Y     = 320,
  parameter int OBST_START_X = 680,
  parameter int OBST_SPEED   = 4,
  parameter int JUMP_V0      = 12,
  parameter int GRAVITY      = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        screen_ready,
  input  logic        jump_btn,
  input  logic        collision_detected,
  output logic [31:0] x_coor,
  output logic [31:0] y_coor,
  output logic [31:0] x_coor_obstacle,
  output logic [31:0] y_coor_obstacle,
  output logic [1:0]  random_generator_clk,
  output logic [15:0] score,
  output logic        game_over,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} game_t;
  typedef enum logic {GROUND = 1'b0, AIR = 1'b1} vert_t;

  localparam logic [11:0] DX   = 12'(DINO_X);
  localparam logic [11:0] GY   = 12'(GROUND_Y);
  localparam logic [11:0] OSX  = 12'(OBST_START_X);
  localparam logic [11:0] OSPD = 12'(OBST_SPEED);
  localparam logic [7:0]  V0   = 8'(JUMP_V0);
  localparam logic [7:0]  GRV  = 8'(GRAVITY);

  game_t              st, st_nxt;
  vert_t              vst;
  logic               sr_q, jump_q, jump_req;
  logic [11:0]        y, xo;
  logic signed [7:0]  vel;
  logic [15:0]        score_r;
  logic [1:0]         rg;

  logic               frame_tick, jump_edge, run_upd, want_jump;
  logic signed [12:0] ny;

  assign frame_tick = screen_ready & ~sr_q;
  assign jump_edge  = jump_btn & ~jump_q;
  // Collision on the tick wins: no motion, score or strobe change that frame.
  assign run_upd    = (st == RUN) && frame_tick && !collision_detected;
  // A press landing on the tick itself is honoured in that same update.
  assign want_jump  = jump_req | jump_edge;
  assign ny         = $signed({1'b0, y}) - 13'(vel);

  // Game FSM: state register
  always_ff @(posedge clk) begin
    if (reset) st <= IDLE;
    else       st <= st_nxt;
  end

  // Game FSM: next state
  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (jump_edge) st_nxt = RUN;
      RUN:     if (frame_tick && collision_detected) st_nxt = OVER;
      OVER:    if (jump_edge) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // Game FSM: outputs
  always_comb begin
    game_over = (st == OVER);
    state     = st;
  end

  // Datapath: edge detectors, vertical physics, obstacle, score, strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q     <= 1'b0;
      jump_q   <= 1'b0;
      jump_req <= 1'b0;
      vst      <= GROUND;
      vel      <= '0;
      y        <= GY;
      xo       <= OSX;
      score_r  <= '0;
      rg       <= 2'b00;
    end else begin
      sr_q   <= screen_ready;
      jump_q <= jump_btn;

      if (st == RUN) begin
        // Requests live for one frame only; the tick always clears them.
        if (frame_tick)     jump_req <= 1'b0;
        else if (jump_edge) jump_req <= 1'b1;
      end

      if (run_upd) begin
        case (vst)
          GROUND: if (want_jump) begin
            vst   <= AIR;
            vel   <= V0;
            rg[1] <= ~rg[1];
          end
          AIR: if (ny >= $signed({1'b0, GY})) begin
            y   <= GY;
            vst <= GROUND;
          end else begin
            y   <= ny[11:0];
            vel <= vel - GRV;
          end
          default: vst <= GROUND;
        endcase

        if (xo < OSPD) begin
          xo    <= OSX;
          rg[0] <= ~rg[0];
          if (score_r != 16'hFFFF) score_r <= score_r + 16'd1;
        end else begin
          xo <= xo - OSPD;
        end
      end

      // Restart from OVER reloads everything except the LFSR strobes.
      if (st == OVER && jump_edge) begin
        jump_req <= 1'b0;
        vst      <= GROUND;
        vel      <= '0;
        y        <= GY;
        xo       <= OSX;
        score_r  <= '0;
      end
    end
  end

  assign x_coor               = {20'd0, DX};
  assign y_coor               = {20'd0, y};
  assign x_coor_obstacle      = {20'd0, xo};
  assign y_coor_obstacle      = {20'd0, GY};
  assign random_generator_clk = rg;
  assign score                = score_r;

endmodule

// File: tb/tb_dino_frame_scheduler.sv
// Directed bench for dino_frame_scheduler. dut1 uses default parameters;
// dut2 spawns its obstacle at 682 so that it reaches xo=2 for the collision
// scenario. Both share clock, reset, screen_ready and jump_btn.
module tb_dino_frame_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, sr, jb, col1, col2;
  logic [31:0] x1, y1, xo1, yo1, x2, y2, xo2, yo2;
  logic [1:0]  rg1, rg2, st1, st2;
  logic [15:0] sc1, sc2;
  logic        go1, go2;

  int n_chk  = 0;
  int n_pass = 0;

  dino_frame_scheduler dut1 (
    .clk(clk), .reset(reset), .screen_ready(sr), .jump_btn(jb),
    .collision_detected(col1),
    .x_coor(x1), .y_coor(y1), .x_coor_obstacle(xo1), .y_coor_obstacle(yo1),
    .random_generator_clk(rg1), .score(sc1), .game_over(go1), .state(st1)
  );

  dino_frame_scheduler #(.OBST_START_X(682)) dut2 (
    .clk(clk), .reset(reset), .screen_ready(sr), .jump_btn(jb),
    .collision_detected(col2),
    .x_coor(x2), .y_coor(y2), .x_coor_obstacle(xo2), .y_coor_obstacle(yo2),
    .random_generator_clk(rg2), .score(sc2), .game_over(go2), .state(st2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // screen_ready high for 'hold' cycles, then low; returns on a negedge.
  task automatic frame(input int hold);
    sr = 1'b1;
    repeat (hold) @(negedge clk);
    sr = 1'b0;
    @(negedge clk);
  endtask

  task automatic press();
    jb = 1'b1;
    @(negedge clk);
    jb = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; sr = 1'b0; jb = 1'b0; col1 = 1'b0; col2 = 1'b0;
    @(negedge clk);
    do_reset();

    // reset state
    check("rst_state", 32'(st1), 0);
    check("rst_x", x1, 100);
    check("rst_y", y1, 320);
    check("rst_xo", xo1, 680);
    check("rst_yo", yo1, 320);
    check("rst_score", 32'(sc1), 0);
    check("rst_go", 32'(go1), 0);
    check("rst_rg", 32'(rg1), 0);

    // collision ignored and nothing moves in IDLE
    col1 = 1'b1;
    frame(1);
    col1 = 1'b0;
    check("idle_state", 32'(st1), 0);
    check("idle_xo", xo1, 680);

    // start: the start press does not become a jump
    press();
    check("start_state", 32'(st1), 1);
    check("start_y", y1, 320);
    frame(1);
    check("start_tick_y", y1, 320);
    check("start_tick_rg", 32'(rg1), 0);
    check("start_tick_xo", xo1, 676);

    // long screen_ready: exactly one update
    frame(8);
    check("long_sr_xo", xo1, 672);

    // sweep to the left edge: 170 ticks total
    repeat (168) frame(1);
    check("sweep_xo", xo1, 0);
    check("sweep_score", 32'(sc1), 0);
    check("sweep_xo2", xo2, 2);

    // tick 171: dut1 respawns, dut2 collides at xo=2
    col2 = 1'b1;
    frame(1);
    col2 = 1'b0;
    check("respawn_xo", xo1, 680);
    check("respawn_score", 32'(sc1), 1);
    check("respawn_rg", 32'(rg1), 1);
    check("coll_state", 32'(st2), 2);
    check("coll_go", 32'(go2), 1);
    check("coll_xo", xo2, 2);
    check("coll_score", 32'(sc2), 0);

    frame(1);
    check("run_xo", xo1, 676);
    check("over_frozen_xo", xo2, 2);
    check("over_frozen_state", 32'(st2), 2);

    // jump on dut1; same press restarts dut2 to IDLE
    press();
    check("restart_state", 32'(st2), 0);
    check("restart_xo", xo2, 682);
    check("restart_score", 32'(sc2), 0);
    check("restart_go", 32'(go2), 0);
    frame(1);
    check("jump_take_y", y1, 320);
    check("jump_rg1", 32'(rg1[1]), 1);

    for (int i = 1; i <= 25; i++) begin
      frame(1);
      case (i)
        1: begin
          check("arc_t1", y1, 308);
          press();
          press();
        end
        2:  check("arc_t2_noreload", y1, 297);
        12: check("arc_apex", y1, 242);
        13: check("arc_t13", y1, 242);
        24: check("arc_t24", y1, 308);
        25: check("arc_land", y1, 320);
        default: ;
      endcase
    end
    check("arc_rg1_once", 32'(rg1[1]), 1);
    frame(1);
    check("ground_stay_y", y1, 320);

    // reset mid-RUN
    check("pre_rst_state", 32'(st1), 1);
    do_reset();
    check("mid_rst_state", 32'(st1), 0);
    check("mid_rst_y", y1, 320);
    check("mid_rst_xo", xo1, 680);
    check("mid_rst_score", 32'(sc1), 0);
    check("mid_rst_go", 32'(go1), 0);
    check("mid_rst_rg", 32'(rg1), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
